alu_ctrl_fsm: RTL and testbench
===============================

Name: alu_ctrl_fsm

Overview:
- Multi-cycle control unit that drives the datapath ALU.
- Fetches instruction words from the instruction ROM using a 6-bit word address.
- Decodes a fixed RV32I subset into the ALU opcode, register addresses, the B-operand immediate, the operand select and the register-file write enable.
- Sequences each instruction through FETCH/DECODE/EXEC/WB, so the ALU sees stable operands for a full EXEC cycle.

Parameters:
- PC_W, 6, width of rom_addr (word address; wraps modulo 2^PC_W).
- RESET_PC, 0, rom_addr value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- instr  input  32  ROM data, combinational from rom_addr.
- rom_addr  output  PC_W  instruction word address; also feeds the ALU auipc path.
- ALUOp  output  5  opcode to ALU: nop=00000, lui=00001, auipc=00010, add=00011, sub=00100, sll=01000, srl=01100, sra=11000.
- rs1, rs2, rd  output  5 each  register-file addresses.
- imm  output  32  immediate for the ALU B operand.
- alu_src_b  output  1  1 = B from imm, 0 = B from rs2 data.
- rf_we  output  1  register-file write strobe, one cycle in WB.
- busy  output  1  1 while not HALT.
- illegal  output  1  sticky; set on an undecodable instruction.

Behaviour:
- Reset (async, rstn=0): state=FETCH, rom_addr=RESET_PC, ALUOp=nop, rs1/rs2/rd/imm=0, alu_src_b=0, rf_we=0, busy=1, illegal=0.
- Every instruction takes 4 cycles: FETCH -> DECODE -> EXEC -> WB -> FETCH.
- FETCH:
  - rom_addr stable; instr registered at the end of the cycle.
  - ALUOp=nop, rf_we=0.
- DECODE: registered instr decoded; rs1/rs2/rd/imm/alu_src_b/ALUOp driven, then held constant through EXEC and WB.
- EXEC: outputs unchanged; ALU result settles.
- WB:
  - rf_we=1 for exactly one cycle when rd!=0; rf_we=0 when rd==0.
  - rom_addr <= rom_addr+1 at the end of WB; 2^PC_W-1 wraps to 0.
- Decode rules (opcode/funct3/funct7):
  - LUI 0110111 -> lui; imm={instr[31:12],12'b0}; alu_src_b=1.
  - AUIPC 0010111 -> auipc; imm as LUI; alu_src_b=1.
  - OP 0110011, f3=000, f7=0000000 -> add.
  - OP 0110011, f3=000, f7=0100000 -> sub.
  - OP 0110011, f3=001 -> sll; f3=101, f7=0 -> srl; f3=101, f7=0100000 -> sra. All OP: alu_src_b=0.
  - OP-IMM 0010011, f3=000 -> add; imm=sign-extended instr[31:20]; alu_src_b=1.
  - OP-IMM 0010011, f3=001/101 -> sll/srl/sra by funct7; imm={27'b0,instr[24:20]}.
- HALT:
  - instr==32'h00000000 decoded in DECODE -> HALT.
  - Any other unlisted encoding -> illegal<=1, then HALT.
  - In HALT: ALUOp=nop, rf_we=0, busy=0, rom_addr frozen. Only rstn leaves HALT.
- Reset asserted mid-instruction aborts it immediately; no rf_we pulse is produced. After release, execution restarts at RESET_PC in FETCH.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- Defined:
  - Adds input port step (1 bit).
  - The FSM waits in WB, holding rf_we low, until step==1 is sampled on a rising edge.
  - That cycle asserts rf_we (if rd!=0) and advances rom_addr; step held high advances once per instruction.
- Undefined: no step port; WB always lasts one cycle.

Test Plan:
- Reset, then rstn=1 with instr=0x00500093 (ADDI x1,x0,5) -> DECODE: ALUOp=00011, rd=1, rs1=0, imm=5, alu_src_b=1. rf_we=1 exactly in cycle 4. rom_addr 0->1 after WB.
- instr=0x002081B3 (ADD x3,x1,x2) then 0x402081B3 (SUB) -> ALUOp 00011 then 00100, rs1=1, rs2=2, rd=3, alu_src_b=0.
- instr=0x4030D293 (SRAI x5,x1,3) -> ALUOp=11000, imm=3, rd=5. instr=0x12345137 (LUI x2) -> ALUOp=00001, imm=0x12345000.
- Run 64 consecutive ADDI words -> rom_addr wraps 63->0. ADDI with rd=0 -> rf_we stays 0 through WB.
- instr=0xFFFFFFFF -> illegal=1, busy=0, ALUOp=nop, rom_addr frozen. instr=0 -> busy=0, illegal=0. Pulse rstn low -> rom_addr=0, busy=1, illegal=0.
- Pull rstn low during EXEC of ADD -> no rf_we pulse; after release, first fetch is from rom_addr=0. With SINGLE_STEP_EN: FSM holds in WB until step=1.

Source files
------------

// File: rtl/alu_ctrl_fsm.sv
// alu_ctrl_fsm: multi-cycle FETCH/DECODE/EXEC/WB control unit for the datapath ALU.
// Decodes a small RV32I subset (LUI, AUIPC, ADD/SUB/SLL/SRL/SRA, ADDI/SLLI/SRLI/SRAI)
// into ALU opcode, register addresses, immediate and write strobe.
// Optional feature: define SINGLE_STEP_EN to add a 'step' input that gates leaving WB.
module alu_ctrl_fsm #(
    parameter int              PC_W     = 6,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rstn,
`ifdef SINGLE_STEP_EN
    input  logic            step,
`endif
    input  logic [31:0]     instr,
    output logic [PC_W-1:0] rom_addr,
    output logic [4:0]      ALUOp,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [31:0]     imm,
    output logic            alu_src_b,
    output logic            rf_we,
    output logic            busy,
    output logic            illegal
);

    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_LUI   = 5'b00001;
    localparam logic [4:0] OP_AUIPC = 5'b00010;
    localparam logic [4:0] OP_ADD   = 5'b00011;
    localparam logic [4:0] OP_SUB   = 5'b00100;
    localparam logic [4:0] OP_SLL   = 5'b01000;
    localparam logic [4:0] OP_SRL   = 5'b01100;
    localparam logic [4:0] OP_SRA   = 5'b11000;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_t;

    state_t state;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    logic [4:0]  dec_aluop;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic [31:0] dec_imm;
    logic        dec_src_b;
    logic        dec_halt;
    logic        dec_illegal;

    logic        halt_pend;
    logic        illegal_pend;

`ifdef SINGLE_STEP_EN
    logic        wb_go;
`endif

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Decode the ROM word; any path that does not reach a legal encoding leaves ALUOp at nop.
    always_comb begin
        dec_aluop   = OP_NOP;
        dec_rs1     = '0;
        dec_rs2     = '0;
        dec_rd      = '0;
        dec_imm     = '0;
        dec_src_b   = 1'b0;
        dec_halt    = 1'b0;
        dec_illegal = 1'b0;
        if (instr == 32'h0000_0000) begin
            dec_halt = 1'b1;
        end else begin
            case (opcode)
                7'b0110111, 7'b0010111: begin
                    dec_aluop = (opcode == 7'b0110111) ? OP_LUI : OP_AUIPC;
                    dec_rd    = instr[11:7];
                    dec_imm   = {instr[31:12], 12'b0};
                    dec_src_b = 1'b1;
                end
                7'b0110011: begin
                    dec_rs1 = instr[19:15];
                    dec_rs2 = instr[24:20];
                    dec_rd  = instr[11:7];
                    case (funct3)
                        3'b000: begin
                            if (funct7 == F7_ZERO)     dec_aluop = OP_ADD;
                            else if (funct7 == F7_ALT) dec_aluop = OP_SUB;
                            else                       dec_illegal = 1'b1;
                        end
                        3'b001: dec_aluop = OP_SLL;
                        3'b101: begin
                            if (funct7 == F7_ZERO)     dec_aluop = OP_SRL;
                            else if (funct7 == F7_ALT) dec_aluop = OP_SRA;
                            else                       dec_illegal = 1'b1;
                        end
                        default: dec_illegal = 1'b1;
                    endcase
                end
                7'b0010011: begin
                    dec_rs1   = instr[19:15];
                    dec_rd    = instr[11:7];
                    dec_src_b = 1'b1;
                    case (funct3)
                        3'b000: begin
                            dec_aluop = OP_ADD;
                            dec_imm   = {{20{instr[31]}}, instr[31:20]};
                        end
                        3'b001: begin
                            dec_imm = {27'b0, instr[24:20]};
                            if (funct7 == F7_ZERO) dec_aluop = OP_SLL;
                            else                   dec_illegal = 1'b1;
                        end
                        3'b101: begin
                            dec_imm = {27'b0, instr[24:20]};
                            if (funct7 == F7_ZERO)     dec_aluop = OP_SRL;
                            else if (funct7 == F7_ALT) dec_aluop = OP_SRA;
                            else                       dec_illegal = 1'b1;
                        end
                        default: dec_illegal = 1'b1;
                    endcase
                end
                default: dec_illegal = 1'b1;
            endcase
        end
    end

    // Sequencer: decode results are captured with the fetched word so they are visible through DECODE/EXEC/WB.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= ST_FETCH;
            rom_addr     <= RESET_PC;
            ALUOp        <= OP_NOP;
            rs1          <= '0;
            rs2          <= '0;
            rd           <= '0;
            imm          <= '0;
            alu_src_b    <= 1'b0;
            rf_we        <= 1'b0;
            busy         <= 1'b1;
            illegal      <= 1'b0;
            halt_pend    <= 1'b0;
            illegal_pend <= 1'b0;
`ifdef SINGLE_STEP_EN
            wb_go        <= 1'b0;
`endif
        end else begin
            case (state)
                ST_FETCH: begin
                    ALUOp        <= dec_aluop;
                    rs1          <= dec_rs1;
                    rs2          <= dec_rs2;
                    rd           <= dec_rd;
                    imm          <= dec_imm;
                    alu_src_b    <= dec_src_b;
                    halt_pend    <= dec_halt;
                    illegal_pend <= dec_illegal;
                    rf_we        <= 1'b0;
                    state        <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (halt_pend || illegal_pend) begin
                        ALUOp   <= OP_NOP;
                        busy    <= 1'b0;
                        illegal <= illegal | illegal_pend;
                        state   <= ST_HALT;
                    end else begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
`ifdef SINGLE_STEP_EN
                    rf_we <= 1'b0;
                    wb_go <= 1'b0;
`else
                    rf_we <= (rd != 5'd0);
`endif
                    state <= ST_WB;
                end
                ST_WB: begin
`ifdef SINGLE_STEP_EN
                    if (!wb_go) begin
                        if (step) begin
                            wb_go <= 1'b1;
                            rf_we <= (rd != 5'd0);
                        end
                    end else begin
                        wb_go    <= 1'b0;
                        rf_we    <= 1'b0;
                        ALUOp    <= OP_NOP;
                        rom_addr <= rom_addr + PC_W'(1);
                        state    <= ST_FETCH;
                    end
`else
                    rf_we    <= 1'b0;
                    ALUOp    <= OP_NOP;
                    rom_addr <= rom_addr + PC_W'(1);
                    state    <= ST_FETCH;
`endif
                end
                ST_HALT: begin
                    ALUOp <= OP_NOP;
                    rf_we <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// tb_alu_ctrl_fsm: scoreboard bench for alu_ctrl_fsm. A ROM array feeds instr from rom_addr;
// expected decode results are queued as words are loaded and popped in each DECODE cycle.
module tb_alu_ctrl_fsm;

    localparam int PC_W = 6;

    typedef struct {
        logic [4:0]  aluop;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        src_b;
        logic [2:0]  chk;
    } exp_t;

    logic            clk = 1'b0;
    logic            rstn = 1'b1;
    logic [31:0]     instr;
    logic [PC_W-1:0] rom_addr;
    logic [4:0]      ALUOp;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     imm;
    logic            alu_src_b;
    logic            rf_we;
    logic            busy;
    logic            illegal;

    logic [31:0]     rom [64];
    exp_t            exp_q [$];
    logic [PC_W-1:0] pc_model;
    int              checks = 0;
    int              failures = 0;

    alu_ctrl_fsm #(.PC_W(PC_W), .RESET_PC('0)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .instr     (instr),
        .rom_addr  (rom_addr),
        .ALUOp     (ALUOp),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .imm       (imm),
        .alu_src_b (alu_src_b),
        .rf_we     (rf_we),
        .busy      (busy),
        .illegal   (illegal)
    );

    assign instr = rom[rom_addr];

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
        end
    endtask

    // chk bit 0: compare rs1, bit 1: compare rs2, bit 2: compare imm
    task automatic applyStimulus(input logic [PC_W-1:0] addr, input logic [31:0] word,
                                 input logic [4:0] aluop, input logic [4:0] e_rs1,
                                 input logic [4:0] e_rs2, input logic [4:0] e_rd,
                                 input logic [31:0] e_imm, input logic e_src_b,
                                 input logic [2:0] chk);
        exp_t e;
        e.aluop = aluop;
        e.rs1   = e_rs1;
        e.rs2   = e_rs2;
        e.rd    = e_rd;
        e.imm   = e_imm;
        e.src_b = e_src_b;
        e.chk   = chk;
        rom[addr] = word;
        exp_q.push_back(e);
    endtask

    task automatic clearRom();
        for (int i = 0; i < 64; i++) rom[i] = 32'h0;
        exp_q.delete();
    endtask

    // Ends at a falling edge in the FETCH cycle that follows reset release.
    task automatic doReset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        pc_model = '0;
    endtask

    // Entry and exit: at a falling edge inside FETCH.
    task automatic runInstr();
        exp_t e;
        checkOutput("fetch_addr", 32'(rom_addr), 32'(pc_model));
        checkOutput("fetch_aluop", 32'(ALUOp), 32'd0);
        checkOutput("fetch_we", 32'(rf_we), 32'd0);
        checkOutput("fetch_busy", 32'(busy), 32'd1);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            checkOutput("scoreboard_underflow", 32'(exp_q.size()), 32'd1);
            repeat (3) @(negedge clk);
            return;
        end
        e = exp_q.pop_front();
        checkOutput("dec_aluop", 32'(ALUOp), 32'(e.aluop));
        checkOutput("dec_rd", 32'(rd), 32'(e.rd));
        checkOutput("dec_src_b", 32'(alu_src_b), 32'(e.src_b));
        checkOutput("dec_we", 32'(rf_we), 32'd0);
        if (e.chk[0]) checkOutput("dec_rs1", 32'(rs1), 32'(e.rs1));
        if (e.chk[1]) checkOutput("dec_rs2", 32'(rs2), 32'(e.rs2));
        if (e.chk[2]) checkOutput("dec_imm", imm, e.imm);
        @(negedge clk);
        checkOutput("exec_aluop", 32'(ALUOp), 32'(e.aluop));
        checkOutput("exec_rd", 32'(rd), 32'(e.rd));
        checkOutput("exec_we", 32'(rf_we), 32'd0);
        @(negedge clk);
        checkOutput("wb_aluop", 32'(ALUOp), 32'(e.aluop));
        checkOutput("wb_we", 32'(rf_we), (e.rd != 5'd0) ? 32'd1 : 32'd0);
        checkOutput("wb_addr", 32'(rom_addr), 32'(pc_model));
        @(negedge clk);
        pc_model = pc_model + PC_W'(1);
    endtask

    // Entry at FETCH of a halting word; checks DECODE, then several HALT cycles.
    task automatic haltSeq(input logic exp_ill, input int cycles);
        logic [PC_W-1:0] frozen;
        frozen = pc_model;
        checkOutput("halt_fetch_addr", 32'(rom_addr), 32'(frozen));
        @(negedge clk);
        checkOutput("halt_dec_aluop", 32'(ALUOp), 32'd0);
        checkOutput("halt_dec_busy", 32'(busy), 32'd1);
        @(negedge clk);
        for (int c = 0; c < cycles; c++) begin
            checkOutput("halt_busy", 32'(busy), 32'd0);
            checkOutput("halt_illegal", 32'(illegal), 32'(exp_ill));
            checkOutput("halt_aluop", 32'(ALUOp), 32'd0);
            checkOutput("halt_we", 32'(rf_we), 32'd0);
            checkOutput("halt_addr", 32'(rom_addr), 32'(frozen));
            @(negedge clk);
        end
    endtask

    initial begin
        logic [11:0] imm12;
        logic [4:0]  rdv;
        logic [4:0]  rs1v;

        clearRom();
        $display("[TB] start");
        #2 rstn = 1'b0;
        @(negedge clk);
        checkOutput("rst_addr", 32'(rom_addr), 32'd0);
        checkOutput("rst_aluop", 32'(ALUOp), 32'd0);
        checkOutput("rst_rs1", 32'(rs1), 32'd0);
        checkOutput("rst_rs2", 32'(rs2), 32'd0);
        checkOutput("rst_rd", 32'(rd), 32'd0);
        checkOutput("rst_imm", imm, 32'd0);
        checkOutput("rst_src_b", 32'(alu_src_b), 32'd0);
        checkOutput("rst_we", 32'(rf_we), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd1);
        checkOutput("rst_illegal", 32'(illegal), 32'd0);

        // Decode of each instruction class, then a clean halt on an all-zero word.
        clearRom();
        applyStimulus(6'd0, 32'h0050_0093, 5'b00011, 5'd0, 5'd0, 5'd1, 32'd5,          1'b1, 3'b101);
        applyStimulus(6'd1, 32'h0020_81B3, 5'b00011, 5'd1, 5'd2, 5'd3, 32'd0,          1'b0, 3'b011);
        applyStimulus(6'd2, 32'h4020_81B3, 5'b00100, 5'd1, 5'd2, 5'd3, 32'd0,          1'b0, 3'b011);
        applyStimulus(6'd3, 32'h4030_D293, 5'b11000, 5'd1, 5'd0, 5'd5, 32'd3,          1'b1, 3'b101);
        applyStimulus(6'd4, 32'h1234_5137, 5'b00001, 5'd0, 5'd0, 5'd2, 32'h1234_5000,  1'b1, 3'b100);
        doReset();
        for (int k = 0; k < 5; k++) runInstr();
        haltSeq(1'b0, 3);

        // Illegal word at address 1: sticky flag, frozen address, reset recovers.
        clearRom();
        applyStimulus(6'd0, 32'h0050_0093, 5'b00011, 5'd0, 5'd0, 5'd1, 32'd5, 1'b1, 3'b101);
        rom[1] = 32'hFFFF_FFFF;
        doReset();
        runInstr();
        haltSeq(1'b1, 4);
        rstn = 1'b0;
        #1;
        checkOutput("ill_rst_addr", 32'(rom_addr), 32'd0);
        checkOutput("ill_rst_busy", 32'(busy), 32'd1);
        checkOutput("ill_rst_illegal", 32'(illegal), 32'd0);
        @(negedge clk);

        // Reset during EXEC of ADD: no write strobe, restart from address 0.
        clearRom();
        applyStimulus(6'd0, 32'h0020_81B3, 5'b00011, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 3'b011);
        doReset();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("abort_we", 32'(rf_we), 32'd0);
            checkOutput("abort_addr", 32'(rom_addr), 32'd0);
        end
        rstn = 1'b1;
        pc_model = '0;
        runInstr();

        // 64 ADDI words: address wraps 63 -> 0, and rd==0 entries never strobe rf_we.
        clearRom();
        for (int i = 0; i < 64; i++) begin
            imm12 = 12'(i * 37 - 1000);
            rdv   = 5'(i % 32);
            rs1v  = 5'(i % 7);
            applyStimulus(6'(i), {imm12, rs1v, 3'b000, rdv, 7'b0010011}, 5'b00011, rs1v, 5'd0,
                          rdv, {{20{imm12[11]}}, imm12}, 1'b1, 3'b101);
        end
        doReset();
        for (int i = 0; i < 64; i++) runInstr();
        checkOutput("wrap_addr", 32'(rom_addr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
